// File: rtl/sc_comparator_lost_multi_players_pkg.sv
// Shared definitions for the multi-player lost comparator: lane state
// encoding, game-over mode selectors and a width helper.
package sc_comparator_lost_multi_players_pkg;

  // Per-player lane states.
  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_GRACE = 2'd1;
  localparam logic [1:0] ST_LOST  = 2'd2;

  // Game-over reduction selectors.
  localparam int GAMEOVER_ALL = 0;
  localparam int GAMEOVER_ANY = 1;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(3) = 2.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Grace counter width; at least one bit even when grace is disabled.
  function automatic int grace_width(input int frames);
    return (frames > 0) ? clog2(frames + 1) : 1;
  endfunction

endpackage

// File: rtl/sc_comparator_lost_lane.sv
// One player lane: overlap reduction, ALIVE/GRACE/LOST state machine,
// lives counter, grace counter and a one-cycle hit pulse.
module sc_comparator_lost_lane
  import sc_comparator_lost_multi_players_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int LIVES_INIT   = 3,
  parameter int GRACE_FRAMES = 2,
  parameter int LIVESWIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  sample,
  input  logic [DATAWIDTH-1:0]  obstacle,
  input  logic [DATAWIDTH-1:0]  player,
  output logic                  hit,
  output logic [LIVESWIDTH-1:0] lives,
  output logic                  lost,
  output logic                  lost_next
);

  localparam int GW = grace_width(GRACE_FRAMES);
  localparam logic [LIVESWIDTH-1:0] LIVES_LOAD = LIVESWIDTH'(LIVES_INIT);
  localparam logic [LIVESWIDTH-1:0] LIVES_ONE  = LIVESWIDTH'(1);
  localparam logic [GW-1:0]         GRACE_LOAD = GW'(GRACE_FRAMES);
  localparam logic [GW-1:0]         GRACE_ONE  = GW'(1);

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [LIVESWIDTH-1:0] lives_n;
  logic [GW-1:0]         grace;
  logic [GW-1:0]         grace_n;
  logic                  hit_n;
  logic                  overlap;

  assign overlap   = |(player & obstacle);
  assign lost      = (state == ST_LOST);
  assign lost_next = (state_n == ST_LOST);

  // Next-state logic; restart outranks sample, and only strobed cycles advance.
  always_comb begin
    state_n = state;
    lives_n = lives;
    grace_n = grace;
    hit_n   = 1'b0;
    if (restart) begin
      state_n = ST_ALIVE;
      lives_n = LIVES_LOAD;
      grace_n = '0;
    end else if (sample) begin
      case (state)
        ST_ALIVE: begin
          if (overlap) begin
            hit_n = 1'b1;
            if (lives <= LIVES_ONE) begin
              lives_n = '0;
              state_n = ST_LOST;
            end else begin
              lives_n = lives - LIVES_ONE;
              if (GRACE_FRAMES > 0) begin
                grace_n = GRACE_LOAD;
                state_n = ST_GRACE;
              end
            end
          end
        end
        ST_GRACE: begin
          if (grace <= GRACE_ONE) begin
            grace_n = '0;
            state_n = ST_ALIVE;
          end else begin
            grace_n = grace - GRACE_ONE;
          end
        end
        ST_LOST: begin
          lives_n = '0;
        end
        default: begin
          state_n = ST_ALIVE;
          lives_n = LIVES_LOAD;
          grace_n = '0;
        end
      endcase
    end
  end

  // State, counters and hit pulse register; reset forces the reload values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ALIVE;
      lives <= LIVES_LOAD;
      grace <= '0;
      hit   <= 1'b0;
    end else begin
      state <= state_n;
      lives <= lives_n;
      grace <= grace_n;
      hit   <= hit_n;
    end
  end

endmodule

// File: rtl/sc_comparator_lost_multi_players.sv
// Multi-player lost comparator: one lane per player against a shared
// obstacle row, plus a registered game-over reduction over the lost flags.
module sc_comparator_lost_multi_players
  import sc_comparator_lost_multi_players_pkg::*;
#(
  parameter int DATAWIDTH     = 8,
  parameter int NPLAYERS      = 2,
  parameter int LIVES_INIT    = 3,
  parameter int GRACE_FRAMES  = 2,
  parameter int GAMEOVER_MODE = 0,
  localparam int LIVESWIDTH   = clog2(LIVES_INIT + 1)
) (
  input  logic                           SC_COMPARATOR_LOST_MULTI_PLAYERS_CLOCK_50,
  input  logic                           SC_COMPARATOR_LOST_MULTI_PLAYERS_RESET_InHigh,
  input  logic                           SC_COMPARATOR_LOST_MULTI_PLAYERS_restart_InHigh,
  input  logic                           SC_COMPARATOR_LOST_MULTI_PLAYERS_sample_InHigh,
  input  logic [DATAWIDTH-1:0]           SC_COMPARATOR_LOST_MULTI_PLAYERS_obstacle_InBUS,
  input  logic [NPLAYERS*DATAWIDTH-1:0]  SC_COMPARATOR_LOST_MULTI_PLAYERS_player_InBUS,
  output logic [NPLAYERS-1:0]            SC_COMPARATOR_LOST_MULTI_PLAYERS_hit_OutHigh,
  output logic [NPLAYERS*LIVESWIDTH-1:0] SC_COMPARATOR_LOST_MULTI_PLAYERS_lives_OutBUS,
  output logic [NPLAYERS-1:0]            SC_COMPARATOR_LOST_MULTI_PLAYERS_lost_OutLow,
  output logic                           SC_COMPARATOR_LOST_MULTI_PLAYERS_gameover_OutLow
);

  logic                clk;
  logic                rst;
  logic [NPLAYERS-1:0] lost;
  logic [NPLAYERS-1:0] lost_next;
  logic                gameover_next;
  logic                gameover;

  assign clk = SC_COMPARATOR_LOST_MULTI_PLAYERS_CLOCK_50;
  assign rst = SC_COMPARATOR_LOST_MULTI_PLAYERS_RESET_InHigh;

  genvar g;
  generate
    for (g = 0; g < NPLAYERS; g++) begin : g_lane
      sc_comparator_lost_lane #(
        .DATAWIDTH    (DATAWIDTH),
        .LIVES_INIT   (LIVES_INIT),
        .GRACE_FRAMES (GRACE_FRAMES),
        .LIVESWIDTH   (LIVESWIDTH)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .restart   (SC_COMPARATOR_LOST_MULTI_PLAYERS_restart_InHigh),
        .sample    (SC_COMPARATOR_LOST_MULTI_PLAYERS_sample_InHigh),
        .obstacle  (SC_COMPARATOR_LOST_MULTI_PLAYERS_obstacle_InBUS),
        .player    (SC_COMPARATOR_LOST_MULTI_PLAYERS_player_InBUS[g*DATAWIDTH +: DATAWIDTH]),
        .hit       (SC_COMPARATOR_LOST_MULTI_PLAYERS_hit_OutHigh[g]),
        .lives     (SC_COMPARATOR_LOST_MULTI_PLAYERS_lives_OutBUS[g*LIVESWIDTH +: LIVESWIDTH]),
        .lost      (lost[g]),
        .lost_next (lost_next[g])
      );
    end
  endgenerate

  // Game over uses next-state lost flags so it lands on the same edge as the lost flag.
  always_comb begin
    gameover_next = 1'b0;
    if (GAMEOVER_MODE == GAMEOVER_ANY) begin
      gameover_next = |lost_next;
    end else begin
      gameover_next = &lost_next;
    end
  end

  // Game-over register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gameover <= 1'b0;
    end else begin
      gameover <= gameover_next;
    end
  end

  assign SC_COMPARATOR_LOST_MULTI_PLAYERS_lost_OutLow     = ~lost;
  assign SC_COMPARATOR_LOST_MULTI_PLAYERS_gameover_OutLow = ~gameover;

endmodule
